// File: rtl/weight_load_if.sv
// Stream-in / memory-write bundle of the weight load controller.
// The master side feeds the word stream and load request; the slave side
// (the controller) presents ready, the two memory write ports and status.
interface weight_load_if;
  logic        load;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic [15:0] cnn_addr;
  logic [15:0] cnn_data;
  logic        cnn_we;
  logic [13:0] fc_addr;
  logic [15:0] fc_data;
  logic        fc_we;
  logic        busy;
  logic        finish_cnn;
  logic        finish_fc;
  logic        done;

  modport master (
    output load, in_valid, in_data,
    input  in_ready, cnn_addr, cnn_data, cnn_we, fc_addr, fc_data, fc_we,
           busy, finish_cnn, finish_fc, done
  );

  modport slave (
    input  load, in_valid, in_data,
    output in_ready, cnn_addr, cnn_data, cnn_we, fc_addr, fc_data, fc_we,
           busy, finish_cnn, finish_fc, done
  );
endinterface

// File: rtl/weight_load_ctrl.sv
// Weight load controller: accepts a stream of 16-bit words and writes the
// first CNN_WORDS into the CNN weight memory, the next FC_WORDS into the FC
// weight memory, then reports completion. Writes lag the accepted beat by
// one cycle; status (ready/busy/done) is decoded directly from the state.
module weight_load_ctrl #(
  parameter int CNN_WORDS = 50704,
  parameter int FC_WORDS  = 11218
) (
  input  logic          clk,
  input  logic          rst,
  weight_load_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_CNN = 2'd1,
    LOAD_FC  = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [15:0] CNN_LAST = 16'(CNN_WORDS - 1);
  localparam logic [15:0] FC_LAST  = 16'(FC_WORDS - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;

  logic        in_ready_c;
  logic        busy_c;
  logic        done_c;
  logic        beat;

  logic        cnn_we_p1;
  logic [15:0] cnn_addr_p1;
  logic [15:0] cnn_data_p1;
  logic        fc_we_p1;
  logic [13:0] fc_addr_p1;
  logic [15:0] fc_data_p1;
  logic        finish_cnn_p1;
  logic        finish_fc_p1;

  // State and word counter register; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: load only starts a sequence from IDLE/DONE; beats
  // advance the counter and the last word of a phase rolls it back to 0.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE, DONE: begin
        if (bus.load) begin
          state_nxt = LOAD_CNN;
          cnt_nxt   = '0;
        end
      end
      LOAD_CNN: begin
        if (bus.in_valid) begin
          if (cnt == CNN_LAST) begin
            state_nxt = LOAD_FC;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end
      end
      LOAD_FC: begin
        if (bus.in_valid) begin
          if (cnt == FC_LAST) begin
            state_nxt = DONE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Status outputs decoded from the current state only.
  always_comb begin
    in_ready_c = (state == LOAD_CNN) || (state == LOAD_FC);
    busy_c     = in_ready_c;
    done_c     = (state == DONE);
    beat       = in_ready_c && bus.in_valid;
  end

  // ---- stage p1: registered memory write ports and finish pulses ----
  // Enables and pulses default low each cycle; address/data hold their last
  // written values between beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnn_we_p1     <= 1'b0;
      cnn_addr_p1   <= '0;
      cnn_data_p1   <= '0;
      fc_we_p1      <= 1'b0;
      fc_addr_p1    <= '0;
      fc_data_p1    <= '0;
      finish_cnn_p1 <= 1'b0;
      finish_fc_p1  <= 1'b0;
    end else begin
      cnn_we_p1     <= 1'b0;
      fc_we_p1      <= 1'b0;
      finish_cnn_p1 <= 1'b0;
      finish_fc_p1  <= 1'b0;
      if (beat && (state == LOAD_CNN)) begin
        cnn_we_p1     <= 1'b1;
        cnn_addr_p1   <= cnt;
        cnn_data_p1   <= bus.in_data;
        finish_cnn_p1 <= (cnt == CNN_LAST);
      end
      if (beat && (state == LOAD_FC)) begin
        fc_we_p1     <= 1'b1;
        fc_addr_p1   <= cnt[13:0];
        fc_data_p1   <= bus.in_data;
        finish_fc_p1 <= (cnt == FC_LAST);
      end
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.cnn_we     = cnn_we_p1;
  assign bus.cnn_addr   = cnn_addr_p1;
  assign bus.cnn_data   = cnn_data_p1;
  assign bus.fc_we      = fc_we_p1;
  assign bus.fc_addr    = fc_addr_p1;
  assign bus.fc_data    = fc_data_p1;
  assign bus.finish_cnn = finish_cnn_p1;
  assign bus.finish_fc  = finish_fc_p1;

endmodule

// File: doc/weight_load_ctrl.md
WEIGHT_LOAD_CTRL -- requirements
Module: weight_load_ctrl

Interface
REQ-001 Parameter CNN_WORDS, default 50704: number of 16-bit CNN weight words per load.
REQ-002 Parameter FC_WORDS, default 11218: number of 16-bit FC weight words per load.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 load  input  1  start request, sampled each cycle.
REQ-006 in_valid  input  1  stream word from io block is valid.
REQ-007 in_data  input  16  stream word.
REQ-008 in_ready  output  1  controller accepts a word this cycle.
REQ-009 cnn_addr  output  16  CNN memory write address.
REQ-010 cnn_data  output  16  CNN memory write data.
REQ-011 cnn_we  output  1  CNN memory write enable.
REQ-012 fc_addr  output  14  FC memory write address.
REQ-013 fc_data  output  16  FC memory write data.
REQ-014 fc_we  output  1  FC memory write enable.
REQ-015 busy  output  1  high in LOAD_CNN or LOAD_FC.
REQ-016 finish_cnn  output  1  one-cycle pulse, last CNN word written.
REQ-017 finish_fc  output  1  one-cycle pulse, last FC word written.
REQ-018 done  output  1  level, full load sequence complete.

Function
REQ-019 FSM states SHALL be IDLE, LOAD_CNN, LOAD_FC, DONE.
REQ-020 IDLE or DONE with load=1 SHALL go to LOAD_CNN next cycle, clear word counter to 0, clear done.
REQ-021 load=1 while in LOAD_CNN or LOAD_FC SHALL be ignored; no restart, no counter change.
REQ-022 in_ready SHALL equal 1 exactly when state is LOAD_CNN or LOAD_FC (decoded from state, independent of in_valid).
REQ-023 Beat = cycle with in_valid=1 and in_ready=1; only beats advance the counter; in_valid=0 stalls with no write.
REQ-024 Beat k (0-based) accepted in LOAD_CNN at cycle t SHALL produce at t+1: cnn_we=1, cnn_addr=k, cnn_data=in_data of cycle t (latency 1, registered).
REQ-025 Beat k in LOAD_FC SHALL produce at t+1: fc_we=1, fc_addr=k[13:0], fc_data=in_data of cycle t.
REQ-026 cnn_we and fc_we SHALL be 0 in any cycle not following a beat; never both 1.
REQ-027 Beat with k=CNN_WORDS-1 in LOAD_CNN SHALL move state to LOAD_FC at t+1, reset counter to 0, pulse finish_cnn at t+1 (same cycle as last CNN write).
REQ-028 Beat with k=FC_WORDS-1 in LOAD_FC SHALL move state to DONE at t+1, pulse finish_fc and set done at t+1.
REQ-029 done SHALL stay 1 in DONE until rst or a new load.
REQ-030 Counter SHALL be 16 bits and never exceed max(CNN_WORDS,FC_WORDS)-1; no wrap within a phase.
REQ-031 Address/data outputs SHALL hold last written values when the corresponding we=0.
REQ-032 No words accepted in IDLE or DONE (in_ready=0); stray in_valid there SHALL be dropped with no effect.

Reset
REQ-033 rst=1 at a rising edge SHALL force state IDLE, counter 0, and all outputs 0 (in_ready, cnn_we, fc_we, busy, finish_cnn, finish_fc, done, addresses, data), with priority over load and beats.
REQ-034 rst mid-load SHALL abandon the sequence; no pending write issues after reset; a later load restarts at CNN address 0.

Verification (CNN_WORDS=4, FC_WORDS=3)
REQ-035 rst, load pulse, in_valid held 1 with data 0x0001..0x0007 -> cnn writes addr 0..3 data 1..4, finish_cnn with addr 3, fc writes addr 0..2 data 5..7, finish_fc and done with fc addr 2.
REQ-036 in_valid toggled 1/0 during LOAD_CNN -> exactly one write per beat, addresses contiguous 0..3, no writes in stall cycles.
REQ-037 load=1 asserted again during LOAD_FC -> ignored; fc_addr continues 1,2; done asserts once.
REQ-038 rst asserted after second CNN beat -> next cycle all outputs 0, state IDLE; subsequent load writes from cnn_addr 0.
REQ-039 In DONE, in_valid=1 -> in_ready=0, no writes; then load=1 -> done clears, busy=1, new sequence from cnn_addr 0.
REQ-040 Default parameters, continuous stream -> finish_cnn after 50704 CNN writes (last addr 50703), finish_fc after 11218 FC writes (last addr 11217).
